rv_mem_arb: RTL and testbench

- Multi-channel memory arbiter for the multicycle RISC-V core: merges NCH requester channels onto one single-port memory with variable wait states.
- Ch0 is instruction fetch and ch1 is data load/store in the default configuration.
- Selectable fixed-priority or round-robin arbitration.
- Watchdog timeout aborts a hung memory access and reports an error to the requester.

---
 rtl/rv_mem_arb.sv | 174 +++++++++++++++++
 tb/tb_rv_mem_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_arb.sv
// Multi-channel arbiter that merges NCH requesters onto one single-port memory with wait states.
// Supports round-robin or fixed-priority arbitration, and a watchdog that aborts hung accesses.
module rv_mem_arb #(
  parameter int unsigned DPWIDTH = 32,
  parameter int unsigned NCH     = 2,
  parameter bit          RR_MODE = 1'b1,
  parameter int unsigned TMO     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH-1:0]           ch_we,
  input  logic [NCH*DPWIDTH-1:0]   ch_addr,
  input  logic [NCH*DPWIDTH-1:0]   ch_wdata,
  output logic [NCH-1:0]           ch_ack,
  output logic [NCH-1:0]           ch_err,
  output logic [DPWIDTH-1:0]       ch_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DPWIDTH-1:0]       mem_addr,
  output logic [DPWIDTH-1:0]       mem_wdata,
  input  logic [DPWIDTH-1:0]       mem_rdata,
  input  logic                     mem_ready
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StErr} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        gnt_q, gnt_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [DPWIDTH-1:0]   addr_q, addr_d;
  logic [DPWIDTH-1:0]   wdata_q, wdata_d;
  logic [DPWIDTH-1:0]   rdata_q, rdata_d;
  logic                 mem_req_q, mem_req_d;
  logic [NCH-1:0]       ch_ack_q, ch_ack_d;
  logic [NCH-1:0]       ch_err_q, ch_err_d;
  logic [DPWIDTH-1:0]   ch_rdata_q, ch_rdata_d;

  logic                 found;
  logic [IW-1:0]        win;
  logic [IW:0]          sum;
  logic                 sel_we;
  logic [DPWIDTH-1:0]   sel_addr;
  logic [DPWIDTH-1:0]   sel_wdata;
  logic [NCH-1:0]       gnt_dec;
  logic [IW-1:0]        nxt_ptr;

  // Scan from the rr pointer (or from 0 in fixed mode), wrapping modulo NCH.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      sum = (IW+1)'(i);
      if (RR_MODE) begin
        sum = sum + {1'b0, rr_q};
        if (sum >= (IW+1)'(NCH)) sum = sum - (IW+1)'(NCH);
      end
      if (!found && ch_req[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    gnt_dec   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (win == IW'(i)) begin
        sel_we    = ch_we[i];
        sel_addr  = ch_addr[i*DPWIDTH +: DPWIDTH];
        sel_wdata = ch_wdata[i*DPWIDTH +: DPWIDTH];
      end
      gnt_dec[i] = (gnt_q == IW'(i));
    end
  end

  assign nxt_ptr = (gnt_q == IW'(NCH-1)) ? '0 : gnt_q + IW'(1);

  // Output registers are loaded with their next-state values so they align with state_q.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_req_d  = 1'b0;
    ch_ack_d   = '0;
    ch_err_d   = '0;
    ch_rdata_d = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StBusy;
          gnt_d     = win;
          we_d      = sel_we;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          mem_req_d = 1'b1;
        end
      end
      StBusy: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_ready) begin
          state_d    = StResp;
          ch_ack_d   = gnt_dec;
          ch_rdata_d = we_q ? rdata_q : mem_rdata;
          if (!we_q) rdata_d = mem_rdata;
        end else if (cnt_q == CW'(TMO-1)) begin
          state_d  = StErr;
          ch_err_d = gnt_dec;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      StResp, StErr: begin
        state_d = StIdle;
        rr_d    = nxt_ptr;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_req_q  <= 1'b0;
      ch_ack_q   <= '0;
      ch_err_q   <= '0;
      ch_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      mem_req_q  <= mem_req_d;
      ch_ack_q   <= ch_ack_d;
      ch_err_q   <= ch_err_d;
      ch_rdata_q <= ch_rdata_d;
    end
  end

  assign ch_ack    = ch_ack_q;
  assign ch_err    = ch_err_q;
  assign ch_rdata  = ch_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Scoreboard bench for rv_mem_arb: a 4-channel round-robin instance and a 2-channel
// fixed-priority instance, each with a behavioural memory and per-channel requesters.
module tb_rv_mem_arb;

  localparam int unsigned W    = 32;
  localparam int unsigned NA   = 4;
  localparam int unsigned TMO  = 16;
  localparam int unsigned NB   = 2;
  localparam int unsigned TMOB = 4;

  typedef struct {
    int           ch;
    bit           we;
    bit           err;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int           wt;
    int           blen;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  logic [NA-1:0]   a_req, a_we, a_ack, a_err;
  logic [NA*W-1:0] a_addr, a_wdata;
  logic [W-1:0]    a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic            a_mreq, a_mwe, a_mready;

  logic [NB-1:0]   b_req, b_we, b_ack, b_err;
  logic [NB*W-1:0] b_addr, b_wdata;
  logic [W-1:0]    b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic            b_mreq, b_mwe, b_mready;

  rv_mem_arb #(.DPWIDTH(W), .NCH(NA), .RR_MODE(1'b1), .TMO(TMO)) u_dut_a (
    .clk(clk), .rst(rst_a), .ch_req(a_req), .ch_we(a_we), .ch_addr(a_addr),
    .ch_wdata(a_wdata), .ch_ack(a_ack), .ch_err(a_err), .ch_rdata(a_rdata),
    .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_rdata(a_mrdata), .mem_ready(a_mready)
  );

  rv_mem_arb #(.DPWIDTH(W), .NCH(NB), .RR_MODE(1'b0), .TMO(TMOB)) u_dut_b (
    .clk(clk), .rst(rst_b), .ch_req(b_req), .ch_we(b_we), .ch_addr(b_addr),
    .ch_wdata(b_wdata), .ch_ack(b_ack), .ch_err(b_err), .ch_rdata(b_rdata),
    .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_rdata(b_mrdata), .mem_ready(b_mready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
    return a ^ 32'hDEAD_BFEF;
  endfunction

  exp_t         sb_a[$];
  exp_t         sb_b[$];
  logic [W-1:0] m_rd = '0;

  int           rq_n[NA], rq_addon[NA], a_start[NA];
  bit           rq_we[NA], a_active[NA];
  logic [W-1:0] rq_addr[NA], rq_wdata[NA];
  int           rqb_n[NB];
  bit           b_active[NB];
  logic [W-1:0] rqb_addr[NB];

  int cyc      = 0;
  int a_blen   = 0;
  int a_rst_at = 0;
  bit a_rst_chk = 1'b0;

  task automatic push_a(input int ch, input bit we, input logic [W-1:0] addr,
                        input logic [W-1:0] wdata, input int wt, input bit err, input int lat);
    exp_t e;
    e.ch = ch; e.we = we; e.err = err; e.addr = addr; e.wdata = wdata;
    e.wt = wt; e.lat = lat;
    e.blen = err ? int'(TMO) : wt + 1;
    if (err) e.rdata = '0;
    else if (we) e.rdata = m_rd;
    else begin
      e.rdata = mem_fn(addr);
      m_rd    = e.rdata;
    end
    sb_a.push_back(e);
  endtask

  task automatic push_b(input int ch, input logic [W-1:0] addr);
    exp_t e;
    e.ch = ch; e.we = 1'b0; e.err = 1'b0; e.addr = addr; e.wdata = '0;
    e.rdata = mem_fn(addr); e.wt = 0; e.blen = 1; e.lat = -1;
    sb_b.push_back(e);
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int c = 0; c < NA; c++) if (rq_n[c] > 0) p = 1'b1;
    for (int c = 0; c < NB; c++) if (rqb_n[c] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb_a.size() != 0 || sb_b.size() != 0 || pending()) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("phase_done", W'(n < budget), 1);
    if (n >= budget) begin
      sb_a.delete();
      sb_b.delete();
      for (int c = 0; c < NA; c++) rq_n[c] = 0;
      for (int c = 0; c < NB; c++) rqb_n[c] = 0;
    end
    repeat (3) @(posedge clk);
  endtask

  // Monitor, requesters and memory models, all acting on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (a_rst_chk) begin
        check_eq("a_rst_mem_req_drop", W'(a_mreq), 0);
        check_eq("a_rst_no_resp", W'(a_ack | a_err), 0);
        rst_a     = 1'b0;
        a_rst_chk = 1'b0;
      end
      if (a_mreq) begin
        a_blen++;
        check_eq("a_req_expected", W'(sb_a.size() != 0), 1);
        if (sb_a.size() != 0) begin
          check_eq("a_mem_addr", a_maddr, sb_a[0].addr);
          check_eq("a_mem_we", W'(a_mwe), W'(sb_a[0].we));
          if (sb_a[0].we) check_eq("a_mem_wdata", a_mwdata, sb_a[0].wdata);
        end
      end
      if ((a_ack | a_err) != '0) begin
        check_eq("a_resp_onehot", W'($countones(a_ack | a_err)), 1);
        check_eq("a_resp_expected", W'(sb_a.size() != 0), 1);
        if (sb_a.size() != 0) begin
          exp_t e;
          logic [NA-1:0] ev;
          e  = sb_a.pop_front();
          ev = '0;
          ev[e.ch] = 1'b1;
          check_eq("a_ack_vec", W'(a_ack), e.err ? '0 : W'(ev));
          check_eq("a_err_vec", W'(a_err), e.err ? W'(ev) : '0);
          check_eq("a_rdata", a_rdata, e.rdata);
          check_eq("a_busy_len", W'(a_blen), W'(e.blen));
          if (e.lat >= 0) check_eq("a_latency", W'(cyc - a_start[e.ch]), W'(e.lat));
        end
        a_blen = 0;
      end
      if (a_rst_at != 0 && a_blen == a_rst_at) begin
        rst_a     = 1'b1;
        a_rst_at  = 0;
        a_rst_chk = 1'b1;
        a_blen    = 0;
        void'(sb_a.pop_front());
        for (int c = 0; c < NA; c++) begin
          a_active[c] = 1'b0;
          rq_n[c]     = rq_n[c] + rq_addon[c];
          rq_addon[c] = 0;
        end
      end
      for (int c = 0; c < NA; c++) begin
        if (a_ack[c] || a_err[c]) begin
          a_active[c] = 1'b0;
          rq_n[c]--;
          rq_addr[c]  = rq_addr[c] + 4;
          rq_wdata[c] = rq_wdata[c] + 1;
        end
        if (!a_active[c] && rq_n[c] > 0 && !rst_a) begin
          a_active[c] = 1'b1;
          a_start[c]  = cyc;
        end
        a_req[c]           = a_active[c];
        a_we[c]            = rq_we[c];
        a_addr[c*W +: W]   = rq_addr[c];
        a_wdata[c*W +: W]  = rq_wdata[c];
      end
      // Memory A: ready after the front entry's wait states; random ready noise while idle.
      if (a_mreq) begin
        a_mready = (sb_a.size() != 0) && (a_blen - 1 == sb_a[0].wt);
        a_mrdata = a_mready ? mem_fn(a_maddr) : (32'hBAD0_0000 | W'(cyc));
      end else begin
        a_mready = 1'($urandom_range(0, 1));
        a_mrdata = $urandom;
      end

      if ((b_ack | b_err) != '0) begin
        check_eq("b_resp_onehot", W'($countones(b_ack | b_err)), 1);
        check_eq("b_resp_expected", W'(sb_b.size() != 0), 1);
        if (sb_b.size() != 0) begin
          exp_t e;
          logic [NB-1:0] ev;
          e  = sb_b.pop_front();
          ev = '0;
          ev[e.ch] = 1'b1;
          check_eq("b_ack_vec", W'(b_ack), W'(ev));
          check_eq("b_err_vec", W'(b_err), 0);
          check_eq("b_rdata", b_rdata, e.rdata);
        end
      end
      for (int c = 0; c < NB; c++) begin
        if (b_ack[c] || b_err[c]) begin
          b_active[c] = 1'b0;
          rqb_n[c]--;
          rqb_addr[c] = rqb_addr[c] + 4;
        end
        if (!b_active[c] && rqb_n[c] > 0) b_active[c] = 1'b1;
        b_req[c]          = b_active[c];
        b_addr[c*W +: W]  = rqb_addr[c];
      end
      b_mready = b_mreq ? 1'b1 : 1'($urandom_range(0, 1));
      b_mrdata = b_mreq ? mem_fn(b_maddr) : $urandom;
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_mrdata = '0; a_mready = 1'b0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_mrdata = '0; b_mready = 1'b0;
    for (int c = 0; c < NA; c++) begin
      rq_n[c] = 0; rq_addon[c] = 0; a_start[c] = 0; rq_we[c] = 1'b0; a_active[c] = 1'b0;
      rq_addr[c] = '0; rq_wdata[c] = '0;
    end
    for (int c = 0; c < NB; c++) begin
      rqb_n[c] = 0; b_active[c] = 1'b0; rqb_addr[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mem_req", W'(a_mreq), 0);
    check_eq("rst_ack", W'(a_ack), 0);
    check_eq("rst_err", W'(a_err), 0);
    check_eq("rst_rdata", a_rdata, 0);
    check_eq("rst_mem_addr", a_maddr, 0);
    check_eq("rst_mem_we", W'(a_mwe), 0);
    check_eq("rst_mem_wdata", a_mwdata, 0);
    check_eq("rst_b_mem_req", W'(b_mreq), 0);
    check_eq("rst_b_ack", W'(b_ack | b_err), 0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(posedge clk);

    // Single read on ch0 with one wait state; fixed-priority instance runs alongside.
    rq_addr[0] = 32'h100; rq_we[0] = 1'b0; rq_n[0] = 1;
    push_a(0, 1'b0, 32'h100, '0, 1, 1'b0, 3);
    rqb_addr[0] = 32'h40; rqb_addr[1] = 32'h80; rqb_n[0] = 3; rqb_n[1] = 1;
    push_b(0, 32'h40); push_b(0, 32'h44); push_b(0, 32'h48); push_b(1, 32'h80);
    wait_idle(200);

    // Write on ch1 with three wait states.
    @(posedge clk);
    rq_addr[1] = 32'h2000; rq_wdata[1] = 32'h1234_5678; rq_we[1] = 1'b1; rq_n[1] = 1;
    push_a(1, 1'b1, 32'h2000, 32'h1234_5678, 3, 1'b0, 5);
    wait_idle(200);

    // ch0 and ch1 contend for four transactions: alternating grants.
    @(posedge clk);
    rq_we[1] = 1'b0;
    rq_addr[0] = 32'h300; rq_addr[1] = 32'h400; rq_n[0] = 2; rq_n[1] = 2;
    push_a(0, 1'b0, 32'h300, '0, 0, 1'b0, 2);
    push_a(1, 1'b0, 32'h400, '0, 0, 1'b0, -1);
    push_a(0, 1'b0, 32'h304, '0, 0, 1'b0, -1);
    push_a(1, 1'b0, 32'h404, '0, 0, 1'b0, -1);
    wait_idle(200);

    // Memory never ready: watchdog abort.
    @(posedge clk);
    rq_addr[0] = 32'h500; rq_n[0] = 1;
    push_a(0, 1'b0, 32'h500, '0, 1000, 1'b1, int'(TMO) + 1);
    wait_idle(200);

    // Ready on the last permitted busy cycle: success wins.
    @(posedge clk);
    rq_addr[1] = 32'h600; rq_n[1] = 1;
    push_a(1, 1'b0, 32'h600, '0, int'(TMO) - 1, 1'b0, int'(TMO) + 1);
    wait_idle(200);

    // rr pointer is 2 here: ch3 must beat ch1.
    @(posedge clk);
    rq_addr[1] = 32'h700; rq_addr[3] = 32'h800; rq_n[1] = 1; rq_n[3] = 1;
    push_a(3, 1'b0, 32'h800, '0, 0, 1'b0, 2);
    push_a(1, 1'b0, 32'h700, '0, 0, 1'b0, -1);
    wait_idle(200);

    // Leave the rr pointer at 1, then reset during ch1's second busy cycle.
    @(posedge clk);
    rq_addr[0] = 32'h900; rq_n[0] = 1;
    push_a(0, 1'b0, 32'h900, '0, 0, 1'b0, 2);
    wait_idle(200);
    @(posedge clk);
    rq_addr[0] = 32'hB00; rq_addr[1] = 32'hA00; rq_addon[0] = 1; a_rst_at = 2;
    push_a(1, 1'b0, 32'hA00, '0, 1000, 1'b0, -1);
    push_a(0, 1'b0, 32'hB00, '0, 0, 1'b0, 2);
    push_a(1, 1'b0, 32'hA00, '0, 0, 1'b0, -1);
    rq_n[1] = 1;
    wait_idle(300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule
